// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial 2-bit-slice adder.
// FSM encoding, slice width and counter sizing helper.
package serial_add_pkg;

  localparam int SLICE = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    int n;
    n = width / SLICE;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requester and serial_add_ctrl.
// The requester drives the master side, the adder the slave side.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout
  );

endinterface

// File: rtl/add2_slice.sv
// Combinational 2-bit adder slice with carry in/out.
// Reused every cycle by the serial controller.
module add2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {2'b00, cin};

endmodule

// File: rtl/serial_add_ctrl.sv
// Serial adder: one 2-bit slice per cycle, LSB first.
// All outputs decode from registers only.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic              clk,
  input logic              rst,
  serial_add_ctrl_if.slave bus
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(NSL - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [CW-1:0]    cnt_q;

  logic             ready;
  logic             busy;
  logic             done;
  logic             accept;
  logic             last;
  logic [1:0]       a_sl;
  logic [1:0]       b_sl;
  logic [1:0]       s_sl;
  logic             c_sl;

  assign accept = bus.start && ready;
  assign last   = (cnt_q == LAST);

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < NSL; k++) begin
      if (cnt_q == CW'(k)) begin
        a_sl = a_q[SLICE*k +: SLICE];
        b_sl = b_q[SLICE*k +: SLICE];
      end
    end
  end

  add2_slice u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .sum  (s_sl),
    .cout (c_sl)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        ready   = 1'b1;
        done    = 1'b1;
        state_d = bus.start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are captured once; later input changes never reach the slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.b;
      carry_q <= bus.cin;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      for (int k = 0; k < NSL; k++) begin
        if (cnt_q == CW'(k)) sum_q[SLICE*k +: SLICE] <= s_sl;
      end
      carry_q <= c_sl;
      if (last) cout_q <= c_sl;
      else      cnt_q  <= cnt_q + CW'(1);
    end
  end

  assign bus.ready = ready;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 16, operand width in bits; SHALL be an even number and at least 2.
REQ-002 Parameter: SLICE, fixed at 2, bits processed per cycle by the adder slice.
REQ-003 Port: clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-005 Port: start  input  1  request to begin an addition; operands captured when accepted.
REQ-006 Port: a  input  WIDTH  operand A; sampled only on acceptance.
REQ-007 Port: b  input  WIDTH  operand B; sampled only on acceptance.
REQ-008 Port: cin  input  1  carry-in; sampled only on acceptance.
REQ-009 Port: ready  output  1  high when start will be accepted (IDLE or DONE).
REQ-010 Port: busy  output  1  high while in RUN.
REQ-011 Port: done  output  1  one-cycle pulse; result is valid.
REQ-012 Port: sum  output  WIDTH  result bits; held until the next acceptance.
REQ-013 Port: cout  output  1  final carry-out; held with sum.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 Acceptance SHALL occur when start=1 and ready=1 at a clock edge. On acceptance, a, b and cin are latched, the slice counter is cleared, and the FSM enters RUN.
REQ-016 In RUN, each cycle SHALL add slice k (bits 2k+1:2k) of the latched A and B plus the carry register via the 2-bit adder slice. This processes slices LSB first, k = 0 .. WIDTH/2-1.
REQ-017 Each RUN cycle SHALL write the slice sum into the sum register bits 2k+1:2k and update the carry register with the slice carry-out.
REQ-018 After slice WIDTH/2-1, the FSM SHALL enter DONE, load cout from the carry register, and assert done for exactly one cycle.
REQ-019 Latency: done SHALL be high in the (WIDTH/2+1)th cycle after the acceptance edge, i.e. 9 cycles for WIDTH=16.
REQ-020 start while busy=1 SHALL be ignored; latched operands and progress are unaffected.
REQ-021 Changes on a, b or cin after acceptance SHALL NOT affect the result.
REQ-022 DONE SHALL last one cycle, then return to IDLE. start during DONE SHALL be accepted (back-to-back), going directly to RUN.
REQ-023 The result SHALL equal (a + b + cin) mod 2^(WIDTH+1), split as {cout, sum}.
REQ-024 The slice counter SHALL be ceil(log2(WIDTH/2)) bits wide (minimum 1) and SHALL NOT wrap while in RUN.
REQ-025 sum and cout SHALL hold stable from DONE until the next acceptance. Partial values during RUN are don't-care to consumers.

Reset
REQ-026 rst=1 at an edge SHALL force the IDLE state and set ready=1, busy=0, done=0, sum=0, cout=0, carry register 0, and counter 0.
REQ-027 rst SHALL take priority over start, including when asserted mid-RUN; the in-flight operation is discarded with no done pulse.
REQ-028 start SHALL be accepted on the first edge after rst deasserts.

Structure
REQ-029 The FSM state encoding and the SLICE constant SHALL live in a shared package, serial_add_pkg.
REQ-030 The 2-bit combinational add SHALL be a sub-module, add2_slice (a[1:0], b[1:0], cin -> sum[1:0], cout), instantiated once.
REQ-031 There SHALL be no combinational path from start, a, b or cin to any output.

Verification (WIDTH=16)
REQ-032 a=0x0001, b=0x0001, cin=0, start pulse -> done on cycle 9, sum=0x0002, cout=0.
REQ-033 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry propagates through all 8 slices).
REQ-034 a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1. Then a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0.
REQ-035 start held high with new operands during RUN -> exactly one done, with the first operands' result. Start in the DONE cycle -> second done exactly 9 cycles later.
REQ-036 rst asserted on RUN cycle 4 -> next cycle shows ready=1, busy=0, sum=0, cout=0, and no done pulse. A new operation then completes correctly.
